// File: rtl/mds_pkg.sv
// Shared constants for the multiplexed display scanner: register map,
// CTRL bit positions and the 7-segment glyph table ({g,f,e,d,c,b,a}).
package mds_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'h8;
    localparam logic [3:0] ADDR_DIV_LO = 4'h9;
    localparam logic [3:0] ADDR_DIV_HI = 4'hA;
    localparam logic [3:0] ADDR_BRIGHT = 4'hB;
    localparam logic [3:0] ADDR_STATUS = 4'hC;

    localparam int CTRL_EN  = 7;
    localparam int CTRL_AL  = 6;
    localparam int CTRL_RBI = 5;
    localparam int CTRL_LT  = 4;
    localparam int CTRL_BI  = 3;
    localparam int CTRL_HEX = 2;

    // en=0, al=1, rbi=1, lt=1, bi=1, hex=1
    localparam logic [7:0] CTRL_RESET = 8'h7C;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/mds_seg_decode.sv
// Combinational BCD/hex to 7-segment decode with lamp test, blanking
// input and ripple-blank control. Output is active-high {dp,g,f,e,d,c,b,a}.
module mds_seg_decode
    import mds_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dp,
    input  logic       hex,
    input  logic       lt,
    input  logic       bi,
    input  logic       blank,
    output logic [7:0] seg
);

    // Later assignments win: lamp test overrides blanking input, which
    // overrides glyph/leading-zero handling.
    always_comb begin
        seg = {dp, GLYPH[bcd]};
        if (bcd > 4'd9 && !hex) seg[6:0] = '0;
        if (blank) seg[6:0] = '0;
        if (!bi) seg = '0;
        if (!lt) seg = '1;
    end

endmodule

// File: rtl/mux_display_scanner.sv
// Multiplexed 7-segment display scanner with register interface.
// Optional brightness PWM is enabled by defining MDS_PWM_EN.
module mux_display_scanner
    import mds_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            address,
    input  logic                  data_write,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    output logic [7:0]            uo_out,
    output logic [NUM_DIGITS-1:0] dig_out,
    output logic                  frame_irq
);

    logic [4:0]            digit_q [8];
    logic [7:0]            ctrl_q;
    logic [DIV_W-1:0]      div_q;
    logic [DIV_W-1:0]      cnt_q;
    logic [2:0]            cur_q;
    logic [3:0]            frame_cnt_q;
    logic                  irq_q;
    logic [15:0]           div_wide;
    logic [15:0]           div_wr;
    logic                  slot_end;
    logic                  wrap;
    logic                  pwm_on;
    logic                  en;
    logic                  al;
    logic                  blank;
    logic [4:0]            cur_val;
    logic [7:0]            seg;
    logic [NUM_DIGITS-1:0] dig_act;

    assign en       = ctrl_q[CTRL_EN];
    assign al       = ctrl_q[CTRL_AL];
    assign div_wide = 16'(div_q);
    assign slot_end = (cnt_q >= div_q);
    assign wrap     = slot_end && (cur_q == 3'(NUM_DIGITS - 1));
    assign cur_val  = digit_q[cur_q];

    always_comb begin
        div_wr = div_wide;
        if (address == ADDR_DIV_HI) div_wr[15:8] = data_in;
        else                        div_wr[7:0]  = data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) digit_q[i] <= '0;
            ctrl_q      <= CTRL_RESET;
            div_q       <= '1;
            cnt_q       <= '0;
            cur_q       <= '0;
            frame_cnt_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            if (en) begin
                if (slot_end) begin
                    cnt_q <= '0;
                    cur_q <= wrap ? 3'd0 : cur_q + 3'd1;
                    if (wrap) frame_cnt_q <= frame_cnt_q + 4'd1;
                end else begin
                    cnt_q <= cnt_q + DIV_W'(1);
                end
            end
            irq_q <= en && wrap;
            if (data_write) begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++)
                    if (address == 4'(i)) digit_q[i] <= data_in[4:0];
                case (address)
                    ADDR_CTRL:   ctrl_q <= data_in & 8'hFC;
                    ADDR_DIV_LO,
                    ADDR_DIV_HI: div_q  <= div_wr[DIV_W-1:0];
                    default:     ;
                endcase
            end
        end
    end

`ifdef MDS_PWM_EN
    logic [3:0] bright_q;
    logic [3:0] pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_q <= 4'hF;
            pwm_q    <= '0;
        end else begin
            pwm_q <= pwm_q + 4'd1;
            if (data_write && address == ADDR_BRIGHT) bright_q <= data_in[3:0];
        end
    end

    assign pwm_on = (pwm_q <= bright_q);
`else
    assign pwm_on = 1'b1;
`endif

    // Digit i is a leading zero when it and every higher digit hold bcd 0;
    // unused array entries above NUM_DIGITS stay zero.
    always_comb begin
        blank = ctrl_q[CTRL_RBI] && (cur_q != 3'd0);
        for (int unsigned i = 0; i < 8; i++)
            if (3'(i) >= cur_q && digit_q[i][3:0] != 4'd0) blank = 1'b0;
    end

    mds_seg_decode u_decode (
        .bcd   (cur_val[3:0]),
        .dp    (cur_val[4]),
        .hex   (ctrl_q[CTRL_HEX]),
        .lt    (ctrl_q[CTRL_LT]),
        .bi    (ctrl_q[CTRL_BI]),
        .blank (blank),
        .seg   (seg)
    );

    // First cycle of each slot (count 0) keeps digits dark to avoid ghosting.
    always_comb begin
        dig_act = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            dig_act[i] = en && (cnt_q != '0) && pwm_on && (cur_q == 3'(i));
    end

    assign uo_out    = !rst_n ? 8'hFF : (al ? ~seg : seg);
    assign dig_out   = al ? ~dig_act : dig_act;
    assign frame_irq = irq_q && en;

    always_comb begin
        data_out = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            if (address == 4'(i)) data_out = {3'b000, digit_q[i]};
        case (address)
            ADDR_CTRL:   data_out = ctrl_q;
            ADDR_DIV_LO: data_out = div_wide[7:0];
            ADDR_DIV_HI: data_out = div_wide[15:8];
            ADDR_STATUS: data_out = {frame_cnt_q, 1'b0, cur_q};
`ifdef MDS_PWM_EN
            ADDR_BRIGHT: data_out = {4'b0000, bright_q};
`endif
            default:     ;
        endcase
    end

endmodule
